// File: rtl/fpu_division.sv
// fpu_division: multi-cycle IEEE-754 binary32 divider, floating1_in / floating2_in.
// A radix-2 restoring divider produces 26 quotient bits, then one cycle
// normalises, rounds (nearest, ties to even) and packs the result.
// Every operand class takes the same path, so latency is constant:
// done rises 29 edges after the accepting edge.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 request pulse, sampled only while busy = 0
//   floating1_in          dividend, captured on the accepting edge
//   floating2_in          divisor,  captured on the accepting edge
//   floating_division_out registered quotient, updated on the done edge
//   done                  one-cycle pulse, result valid from this cycle
//   busy                  high from acceptance through the done cycle
module fpu_division (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] floating1_in,
  input  logic [31:0] floating2_in,
  output logic [31:0] floating_division_out,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_ROUND, S_DONE} state_e;
  state_e state_q, state_d;

  logic [31:0]       op_a_q, op_b_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]       mb_q;
  logic [24:0]       rem_q;
  logic [25:0]       quo_q;
  logic [4:0]        cnt_q;
  logic              spec_q;
  logic [31:0]       spec_res_q, res_q;
  logic              done_q;

  // done is registered off the DONE state so the output and the pulse
  // move on the same edge; busy covers the done cycle too.
  assign done   = done_q;
  assign busy   = (state_q != S_IDLE) | done_q;

  logic accept;
  assign accept = (state_q == S_IDLE) & start & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_DIV;
      S_DIV:   if (cnt_q == 5'd25) state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Unpack and classify. Denormals (exp = 0) are treated as zero.
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        sgn, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic        spec_d;
  logic [31:0] spec_res_d;
  logic signed [9:0] exp_calc;

  assign ea     = op_a_q[30:23];
  assign eb     = op_b_q[30:23];
  assign fa     = op_a_q[22:0];
  assign fb     = op_b_q[22:0];
  assign sgn    = op_a_q[31] ^ op_b_q[31];
  assign nan_a  = (ea == 8'hFF) & (fa != 23'd0);
  assign nan_b  = (eb == 8'hFF) & (fb != 23'd0);
  assign inf_a  = (ea == 8'hFF) & (fa == 23'd0);
  assign inf_b  = (eb == 8'hFF) & (fb == 23'd0);
  assign zero_a = (ea == 8'h00);
  assign zero_b = (eb == 8'h00);
  assign exp_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

  always_comb begin
    spec_d     = 1'b1;
    spec_res_d = 32'h7FC0_0000;
    if (nan_a | nan_b)                              spec_res_d = 32'h7FC0_0000;
    else if ((zero_a & zero_b) | (inf_a & inf_b))   spec_res_d = 32'h7FC0_0000;
    else if (inf_a | zero_b)                        spec_res_d = {sgn, 8'hFF, 23'd0};
    else if (zero_a | inf_b)                        spec_res_d = {sgn, 31'd0};
    else                                            spec_d     = 1'b0;
  end

  // One restoring step: the partial remainder is always < 2*mb, so after
  // a successful subtract it fits in 24 bits before the left shift.
  logic        q_bit;
  logic [23:0] rem_sub;
  assign q_bit   = rem_q >= {1'b0, mb_q};
  assign rem_sub = q_bit ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];

  // Normalise, round and pack. After normalisation qn[25] is the hidden
  // bit, qn[1] the guard, qn[0] the round bit and the remainder the sticky.
  logic [25:0]       qn;
  logic signed [9:0] en, ef;
  logic              rup;
  logic [24:0]       msum;
  logic [31:0]       norm_res;

  always_comb begin
    if (quo_q[25]) begin
      qn = quo_q;
      en = exp_q;
    end else begin
      qn = {quo_q[24:0], 1'b0};
      en = exp_q - 10'sd1;
    end
    rup  = qn[1] & (qn[0] | (|rem_q) | qn[2]);
    msum = {1'b0, qn[25:2]} + {24'd0, rup};
    // A carry out leaves the fraction bits all zero, so only e moves.
    ef   = msum[24] ? en + 10'sd1 : en;
    if (ef >= 10'sd255)   norm_res = {sign_q, 8'hFF, 23'd0};
    else if (ef <= 10'sd0) norm_res = {sign_q, 31'd0};
    else                   norm_res = {sign_q, ef[7:0], msum[22:0]};
  end

  logic unused_bits;
  assign unused_bits = ^{msum[23], ef[9:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q                <= '0;
      op_b_q                <= '0;
      sign_q                <= 1'b0;
      exp_q                 <= '0;
      mb_q                  <= '0;
      rem_q                 <= '0;
      quo_q                 <= '0;
      cnt_q                 <= '0;
      spec_q                <= 1'b0;
      spec_res_q            <= '0;
      res_q                 <= '0;
      floating_division_out <= '0;
      done_q                <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      if (accept) begin
        op_a_q <= floating1_in;
        op_b_q <= floating2_in;
      end
      case (state_q)
        S_LOAD: begin
          sign_q     <= sgn;
          exp_q      <= exp_calc;
          mb_q       <= {1'b1, fb};
          rem_q      <= {2'b01, fa};
          quo_q      <= '0;
          cnt_q      <= '0;
          spec_q     <= spec_d;
          spec_res_q <= spec_res_d;
        end
        S_DIV: begin
          rem_q <= {rem_sub, 1'b0};
          quo_q <= {quo_q[24:0], q_bit};
          cnt_q <= cnt_q + 5'd1;
        end
        S_ROUND: res_q <= spec_q ? spec_res_q : norm_res;
        S_DONE:  floating_division_out <= res_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_division.sv
// tb_fpu_division: self-checking bench for fpu_division. Directed vectors,
// randomized operands against an exact-arithmetic reference model,
// latency, start-while-busy and mid-operation reset scenarios.
module tb_fpu_division;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] fa, fb;
  logic [31:0] out;
  logic        done, busy;

  int tests = 0;
  int fails = 0;

  fpu_division dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .floating1_in          (fa),
    .floating2_in          (fb),
    .floating_division_out (out),
    .done                  (done),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  // Reference: exact integer division of the significands, normalised so
  // the integer quotient has 24 bits, then RNE by comparing 2*remainder
  // with the divisor.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  xa, xb;
    logic [22:0] ma_f, mb_f;
    logic [63:0] ma, mb, num, q, r;
    int          e;
    s = a[31] ^ b[31];
    xa = a[30:23]; xb = b[30:23]; ma_f = a[22:0]; mb_f = b[22:0];
    if ((xa == 8'hFF && ma_f != 0) || (xb == 8'hFF && mb_f != 0)) return 32'h7FC00000;
    if ((xa == 0 && xb == 0) || (xa == 8'hFF && xb == 8'hFF)) return 32'h7FC00000;
    if (xa == 8'hFF || xb == 0) return {s, 8'hFF, 23'h0};
    if (xa == 0 || xb == 8'hFF) return {s, 31'h0};
    ma = {40'd1, ma_f}; mb = {40'd1, mb_f};
    e = int'(xa) - int'(xb) + 127;
    if (ma >= mb) num = ma << 23;
    else begin
      num = ma << 24;
      e = e - 1;
    end
    q = num / mb;
    r = num % mb;
    if ((2 * r > mb) || ((2 * r == mb) && q[0])) q = q + 1;
    if (q == 64'h1000000) begin
      q = 64'h800000;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0: ;
      1: begin
        case ($urandom_range(0, 4))
          0: v[30:0] = 31'd0;
          1: v[30:0] = {8'hFF, 23'h0};
          2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
          3: v[30:23] = 8'h00;
          default: v[30:23] = (v[0]) ? 8'($urandom_range(250, 254)) : 8'($urandom_range(1, 4));
        endcase
      end
      default: v[30:23] = 8'($urandom_range(110, 145));
    endcase
    return v;
  endfunction

  // Issue one division once the unit is free; returns the result and the
  // number of edges from acceptance to done (capped at 100).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    fa = a; fb = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    fa = $urandom; fb = $urandom;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    res = out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; fa = '0; fb = '0;
    #12;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (out !== 32'h0) begin fails++; $display("FAIL reset_out got %h want 00000000", out); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [31:0] va [11] = '{32'h40400000, 32'h41000000, 32'hC0800000, 32'hC1FC0000,
                             32'h41280000, 32'h4148F5C3, 32'h00000000, 32'h3F800000,
                             32'h00000000, 32'h7F800000, 32'h7F7FFFFF};
    logic [31:0] vb [11] = '{32'h40000000, 32'h40000000, 32'h40800000, 32'h40600000,
                             32'h40200000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                             32'h00000000, 32'h3F800000, 32'h00800000};
    logic [31:0] ve [11] = '{32'h3FC00000, 32'h40800000, 32'hBF800000, 32'hC1100000,
                             32'h40866666, 32'h4148F5C3, 32'h00000000, 32'h7F800000,
                             32'h7FC00000, 32'h7F800000, 32'h7F800000};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 11; i++) begin
      run_op(va[i], vb[i], r, lat);
      tests++;
      if (r !== ve[i]) begin
        fails++;
        $display("FAIL directed[%0d] %h/%h got %h want %h", i, va[i], vb[i], r, ve[i]);
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] r;
    int lat;
    run_op(32'h40400000, 32'h3F800000, r, lat);
    tests++; if (lat !== 29) begin fails++; $display("FAIL latency got %0d want 29", lat); end
    tests++; if (r !== 32'h40400000) begin fails++; $display("FAIL latency_res got %h want 40400000", r); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_pulse got %b want 0", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_done got %b want 0", busy); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, exp_r;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a = rand_operand();
      b = rand_operand();
      exp_r = ref_div(a, b);
      run_op(a, b, r, lat);
      tests++;
      if (r !== exp_r) begin
        fails++;
        $display("FAIL random[%0d] %h/%h got %h want %h", i, a, b, r, exp_r);
      end
      tests++;
      if (lat !== 29) begin fails++; $display("FAIL random_lat[%0d] got %0d want 29", i, lat); end
    end
  endtask

  task automatic test_start_held();
    logic [31:0] a, b;
    int cnt;
    bit got;
    a = 32'h40E00000; b = 32'h40400000;  // 7/3
    @(negedge clk);
    while (busy) @(negedge clk);
    fa = a; fb = b; start = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL held_busy got %b want 1", busy); end
    cnt = 0; got = 0;
    while (cnt < 100 && !got) begin
      @(negedge clk);
      fa = $urandom; fb = $urandom;
      @(posedge clk); #1;
      cnt++;
      if (done) got = 1;
    end
    tests++; if (cnt !== 29) begin fails++; $display("FAIL held_lat got %0d want 29", cnt); end
    tests++;
    if (out !== ref_div(a, b)) begin
      fails++; $display("FAIL held_res got %h want %h", out, ref_div(a, b));
    end
    // start stays high through the done cycle: that edge must not accept
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL held_no_restart got %b want 0", busy); end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    while (busy) @(negedge clk);
    fa = 32'h41280000; fb = 32'h40200000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL midrst_done got %b want 0", done); end
    tests++; if (out !== 32'h0) begin fails++; $display("FAIL midrst_out got %h want 00000000", out); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_quiet got %b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int l1, l2;
    run_op(32'h41000000, 32'h40800000, r1, l1);
    run_op(32'hC1FC0000, 32'h40600000, r2, l2);
    tests++; if (r1 !== 32'h40000000) begin fails++; $display("FAIL b2b_first got %h want 40000000", r1); end
    tests++; if (r2 !== 32'hC1100000) begin fails++; $display("FAIL b2b_second got %h want C1100000", r2); end
    tests++; if (l2 !== 29) begin fails++; $display("FAIL b2b_lat got %0d want 29", l2); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_random();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
